dsp48_mac_sequencer: RTL and testbench

Feeds the DSP48A1 slice with operand streams, drives its clock-enable and OPMODE, and returns one dot product per sequence. It sits upstream of the DSP slice, which has a configurable register/bypass pipeline, and also on its output side. Operand pairs (A,B) arrive on a valid/ready stream with a last flag. The block issues them to the slice as MUL-then-MAC operations and waits for the slice's fixed pipeline latency. It then captures P and presents it on a valid/ready output.

---
 rtl/dsp48_pkg.sv | 20 ++
 rtl/dsp_ce_delay_line.sv | 37 +++
 rtl/dsp48_mac_sequencer.sv | 143 ++++++++++++++
 tb/tb_dsp48_mac_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp48_pkg.sv
// Shared constants and FSM encoding for the DSP48A1 MAC sequencer.
package dsp48_pkg;

  localparam logic [7:0] OPM_MUL  = 8'h01;  // P = A*B
  localparam logic [7:0] OPM_MAC  = 8'h09;  // P = P + A*B
  localparam logic [7:0] OPM_ZERO = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  // Drain counter start value; DRAIN lasts LATENCY cycles including the capture cycle.
  function automatic logic [2:0] drain_init(input int latency);
    return 3'(latency - 1);
  endfunction

endpackage

// File: rtl/dsp_ce_delay_line.sv
// Clock-enabled shift register with asynchronous reset; DEPTH=0 is a plain wire.
module dsp_ce_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             i_ce,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign o_q = i_d;
    end else begin : g_pipe
      logic [WIDTH-1:0] r_stage [DEPTH];

      // Stages advance only together with the slice registers they shadow.
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          for (int i = 0; i < DEPTH; i++) begin
            r_stage[i] <= {WIDTH{1'b0}};
          end
        end else if (i_ce) begin
          r_stage[0] <= i_d;
          for (int i = 1; i < DEPTH; i++) begin
            r_stage[i] <= r_stage[i-1];
          end
        end
      end

      assign o_q = r_stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/dsp48_mac_sequencer.sv
// Streams operand pairs into a DSP48A1 slice as MUL-then-MAC and returns one
// dot product per sequence after the slice pipeline has drained.
module dsp48_mac_sequencer
  import dsp48_pkg::*;
#(
  parameter int WIDTH   = 18,
  parameter int PWIDTH  = 48,
  parameter int LATENCY = 4,
  parameter int OPM_DLY = 2,
  parameter int CNTW    = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  input  logic              in_last,
  output logic [WIDTH-1:0]  dsp_a,
  output logic [WIDTH-1:0]  dsp_b,
  output logic [7:0]        dsp_opmode,
  output logic              dsp_ce,
  input  logic [PWIDTH-1:0] dsp_p,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PWIDTH-1:0] out_p,
  output logic [CNTW-1:0]   out_count
);

  localparam logic [2:0]      DRAIN_INIT = drain_init(LATENCY);
  localparam logic [CNTW-1:0] CNT_ONE    = CNTW'(1);
  localparam logic [CNTW-1:0] CNT_MAX    = {CNTW{1'b1}};

  state_t          r_state;
  logic [CNTW-1:0] r_count;
  logic [2:0]      r_drain;
  logic            w_accept;
  logic            w_ce;
  logic [7:0]      w_opm_issue;

  // Handshake, slice clock enable and the opmode entering the delay line.
  always_comb begin
    in_ready    = 1'b0;
    w_ce        = 1'b0;
    w_opm_issue = OPM_ZERO;
    case (r_state)
      ST_IDLE: begin
        in_ready    = ~RST;
        w_ce        = in_valid & ~RST;
        w_opm_issue = OPM_MUL;
      end
      ST_STREAM: begin
        in_ready    = ~RST;
        w_ce        = in_valid & ~RST;
        w_opm_issue = OPM_MAC;
      end
      ST_DRAIN: begin
        w_ce        = ~RST;
        w_opm_issue = OPM_MAC;
      end
      ST_HOLD: begin
        w_ce        = 1'b0;
        w_opm_issue = OPM_ZERO;
      end
      default: begin
        w_ce        = 1'b0;
        w_opm_issue = OPM_ZERO;
      end
    endcase
  end

  assign w_accept = in_valid & in_ready;
  assign dsp_ce   = w_ce;
  assign dsp_a    = w_accept ? in_a : {WIDTH{1'b0}};
  assign dsp_b    = w_accept ? in_b : {WIDTH{1'b0}};

  dsp_ce_delay_line #(
    .WIDTH (8),
    .DEPTH (OPM_DLY)
  ) u_opm_dly (
    .CLK  (CLK),
    .RST  (RST),
    .i_ce (w_ce),
    .i_d  (w_opm_issue),
    .o_q  (dsp_opmode)
  );

  // Sequence FSM with registered result outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      r_count   <= {CNTW{1'b0}};
      r_drain   <= 3'd0;
      out_valid <= 1'b0;
      out_p     <= {PWIDTH{1'b0}};
      out_count <= {CNTW{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_count <= CNT_ONE;
            if (in_last) begin
              r_drain <= DRAIN_INIT;
              r_state <= ST_DRAIN;
            end else begin
              r_state <= ST_STREAM;
            end
          end
        end
        ST_STREAM: begin
          if (w_accept) begin
            r_count <= (r_count == CNT_MAX) ? r_count : r_count + CNT_ONE;
            if (in_last) begin
              r_drain <= DRAIN_INIT;
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // The last product reaches P one edge before the counter expires.
          if (r_drain == 3'd0) begin
            out_p     <= dsp_p;
            out_count <= r_count;
            out_valid <= 1'b1;
            r_state   <= ST_HOLD;
          end else begin
            r_drain <= r_drain - 3'd1;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dsp48_mac_sequencer.sv
// Scoreboard bench for dsp48_mac_sequencer with a behavioural DSP48A1 slice
// (A/B regs x2, M reg, OPMODE reg, P reg).
module tb_dsp48_mac_sequencer;

  localparam int LAT = 4;

  logic               CLK = 1'b0;
  logic               RST = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [17:0] in_a = 18'sd0;
  logic signed [17:0] in_b = 18'sd0;
  logic               in_last = 1'b0;
  logic [17:0]        dsp_a, dsp_b;
  logic [7:0]         dsp_opmode;
  logic               dsp_ce;
  logic [47:0]        dsp_p;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [47:0]        out_p;
  logic [7:0]         out_count;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  dsp48_mac_sequencer #(
    .WIDTH(18), .PWIDTH(48), .LATENCY(LAT), .OPM_DLY(2), .CNTW(8)
  ) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode), .dsp_ce(dsp_ce), .dsp_p(dsp_p),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .out_count(out_count)
  );

  // Behavioural slice: all registers share dsp_ce and are never reset.
  logic signed [17:0] a1 = 18'sd0, b1 = 18'sd0, a2 = 18'sd0, b2 = 18'sd0;
  logic signed [35:0] m_r = 36'sd0;
  logic [7:0]         opm_r = 8'h00;
  logic [47:0]        p_r = 48'd0;
  logic [7:0]         opm_log [$];

  always @(posedge CLK) begin
    if (dsp_ce) begin
      a1    <= dsp_a;
      b1    <= dsp_b;
      a2    <= a1;
      b2    <= b1;
      m_r   <= a2 * b2;
      opm_r <= dsp_opmode;
      if (m_r != 36'sd0) opm_log.push_back(opm_r);
      case (opm_r)
        8'h01:   p_r <= {{12{m_r[35]}}, m_r};
        8'h09:   p_r <= p_r + {{12{m_r[35]}}, m_r};
        8'h00:   p_r <= 48'd0;
        default: p_r <= p_r;
      endcase
    end
  end
  assign dsp_p = p_r;

  typedef struct {
    logic [47:0] p;
    logic [7:0]  cnt;
    int          cyc;
  } exp_t;

  exp_t sb [$];
  exp_t cur;
  logic prev_valid = 1'b0;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic signed [47:0] p, input logic [7:0] cnt, input int when);
    exp_t e;
    e.p = p;
    e.cnt = cnt;
    e.cyc = when;
    sb.push_back(e);
  endtask

  // Monitor: pops on each new result, then checks it stays frozen while held.
  always @(negedge CLK) begin
    if (RST) begin
      prev_valid <= 1'b0;
    end else begin
      if (out_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_result actual out_p=%0h expected=no result", out_p);
        end else begin
          cur = sb.pop_front();
          check("result_p", out_p, cur.p);
          check("result_count", {40'd0, out_count}, {40'd0, cur.cnt});
          check("result_cycle", 48'(cyc), 48'(cur.cyc));
        end
      end else if (out_valid) begin
        check("hold_p", out_p, cur.p);
        check("hold_count", {40'd0, out_count}, {40'd0, cur.cnt});
        check("hold_in_ready", {47'd0, in_ready}, 48'd0);
      end
      prev_valid <= out_valid;
    end
  end

  // Presents one pair and returns the number of the edge that accepted it.
  task automatic send_pair(input logic signed [17:0] a, input logic signed [17:0] b,
                           input logic last, output int edge_no);
    int k;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_last = last;
    k = 0;
    @(negedge CLK);
    while (!in_ready && k < 50) begin
      @(negedge CLK);
      k++;
    end
    check("accept_timeout", {47'd0, (k >= 50)}, 48'd0);
    @(posedge CLK);
    #1;
    edge_no = cyc;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_a = 18'sd0;
    in_b = 18'sd0;
  endtask

  task automatic gap(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(negedge CLK);
      check("gap_ce", {47'd0, dsp_ce}, 48'd0);
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((sb.size() != 0 || out_valid) && k < 400) begin
      @(posedge CLK);
      #1;
      k++;
    end
    check("drain_timeout", {47'd0, (k >= 400)}, 48'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, e;
    int k;

    // Reset values
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_out_valid", {47'd0, out_valid}, 48'd0);
    check("rst_out_p", out_p, 48'd0);
    check("rst_out_count", {40'd0, out_count}, 48'd0);
    check("rst_in_ready", {47'd0, in_ready}, 48'd0);
    check("rst_dsp_ce", {47'd0, dsp_ce}, 48'd0);
    check("rst_opmode", {40'd0, dsp_opmode}, 48'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;

    // Single pair: 3*5
    send_pair(18'sd3, 18'sd5, 1'b1, e0);
    push_exp(48'sd15, 8'd1, e0 + LAT);
    wait_idle();

    // Contiguous (1,2),(3,4),(5,6) with opmode alignment at the post-adder
    opm_log.delete();
    send_pair(18'sd1, 18'sd2, 1'b0, e0);
    send_pair(18'sd3, 18'sd4, 1'b0, e);
    send_pair(18'sd5, 18'sd6, 1'b1, e);
    push_exp(48'sd44, 8'd3, e0 + 2 + LAT);
    wait_idle();
    check("opm_log_size", 48'(opm_log.size()), 48'd3);
    if (opm_log.size() == 3) begin
      check("opm_first", {40'd0, opm_log[0]}, 48'h01);
      check("opm_second", {40'd0, opm_log[1]}, 48'h09);
      check("opm_third", {40'd0, opm_log[2]}, 48'h09);
    end

    // Same sequence with a 2-cycle gap after the second pair
    send_pair(18'sd1, 18'sd2, 1'b0, e0);
    send_pair(18'sd3, 18'sd4, 1'b0, e);
    gap(2);
    send_pair(18'sd5, 18'sd6, 1'b1, e);
    push_exp(48'sd44, 8'd3, e0 + 2 + 2 + LAT);
    wait_idle();

    // Negative operands: -7*9 + 2*-3 = -69
    send_pair(-18'sd7, 18'sd9, 1'b0, e0);
    send_pair(18'sd2, -18'sd3, 1'b1, e);
    push_exp(-48'sd69, 8'd2, e0 + 1 + LAT);
    wait_idle();

    // Consumer stalls for 10 cycles
    out_ready = 1'b0;
    send_pair(18'sd6, 18'sd7, 1'b1, e0);
    push_exp(48'sd42, 8'd1, e0 + LAT);
    k = 0;
    while (!out_valid && k < 50) begin
      @(negedge CLK);
      k++;
    end
    check("hold_wait_timeout", {47'd0, (k >= 50)}, 48'd0);
    repeat (10) begin
      @(negedge CLK);
      check("hold_valid", {47'd0, out_valid}, 48'd1);
      @(posedge CLK);
    end
    #1;
    out_ready = 1'b1;
    wait_idle();
    send_pair(18'sd2, 18'sd2, 1'b1, e0);
    push_exp(48'sd4, 8'd1, e0 + LAT);
    wait_idle();

    // Reset during DRAIN drops the sequence
    send_pair(18'sd4, 18'sd4, 1'b1, e0);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    @(negedge CLK);
    check("abort_out_valid", {47'd0, out_valid}, 48'd0);
    check("abort_in_ready", {47'd0, in_ready}, 48'd0);
    check("abort_dsp_ce", {47'd0, dsp_ce}, 48'd0);
    check("abort_dsp_a", {30'd0, dsp_a}, 48'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    repeat (8) begin
      @(negedge CLK);
      check("abort_no_result", {47'd0, out_valid}, 48'd0);
    end
    @(posedge CLK);
    #1;
    send_pair(18'sd1, 18'sd1, 1'b1, e0);
    push_exp(48'sd1, 8'd1, e0 + LAT);
    wait_idle();

    // 300 pairs: count saturates, sum does not
    send_pair(18'sd1, 18'sd1, 1'b0, e0);
    for (int i = 1; i < 300; i++) begin
      send_pair(18'sd1, 18'sd1, (i == 299), e);
    end
    push_exp(48'sd300, 8'd255, e0 + 299 + LAT);
    wait_idle();

    check("sb_empty", 48'(sb.size()), 48'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
